// File: rtl/tick_sample_fifo_pkg.sv
// tick_sample_fifo_pkg
//   Shared TX-chain definitions used by the tick-paced sample buffer:
//   - SAMPLE_WIDTH  : default sample width in bits
//   - IDLE_MIDSCALE : idle sample (mid-scale for an unsigned DAC)
//   - level_width() : occupancy counter width for a given FIFO depth
package tick_sample_fifo_pkg;

  localparam int unsigned SAMPLE_WIDTH = 8;

  localparam logic [SAMPLE_WIDTH-1:0] IDLE_MIDSCALE = 8'h80;

  // The counter needs one more bit than the pointers so it can hold 0..DEPTH.
  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : tick_sample_fifo_pkg

// File: rtl/tick_sample_fifo_if.sv
// tick_sample_fifo_if
//   Groups the sample input handshake and the DAC output side.
//   s_data / s_valid / s_ready : upstream valid/ready sample stream
//   m_data / m_strobe          : registered sample and one-cycle new-sample pulse
//   Modports:
//     master : the environment (drives samples, observes the DAC side)
//     slave  : the buffer itself
interface tick_sample_fifo_if
  import tick_sample_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SAMPLE_WIDTH
);

  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_strobe;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready,
    input  m_data,
    input  m_strobe
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready,
    output m_data,
    output m_strobe
  );

endinterface : tick_sample_fifo_if

// File: rtl/tick_sample_fifo_sync_fifo_core.sv
// sync_fifo_core
//   Single-clock FIFO: register-array storage, wrapping pointers, occupancy
//   counter and full/empty flags. Requests are qualified internally, so a
//   write while full or a read while empty is ignored.
//   clk, rst         : clock, asynchronous active-low reset
//   wr_en_i/wr_data_i: write request and data
//   rd_en_i          : read request (advances the read pointer)
//   rd_data_o        : entry at the read pointer (combinational)
//   full_o, empty_o  : occupancy flags
//   level_o          : occupancy, 0..DEPTH
module sync_fifo_core
  import tick_sample_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SAMPLE_WIDTH,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en_i,
  input  logic [DATA_WIDTH-1:0]         wr_data_i,
  input  logic                          rd_en_i,
  output logic [DATA_WIDTH-1:0]         rd_data_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [level_width(DEPTH)-1:0] level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = level_width(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q,  level_d;
  logic                  push;
  logic                  pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);

  assign push = wr_en_i && !full_o;
  assign pop  = rd_en_i && !empty_o;

  // Writes only happen when not full, so the slot being written is never the
  // one being read in the same cycle; a plain array read is hazard-free.
  assign rd_data_o = mem_q[rd_ptr_q];
  assign level_o   = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule : sync_fifo_core

// File: rtl/tick_sample_fifo.sv
// tick_sample_fifo
//   Sample buffer between the modulator/host and the DAC/PWM stage. Samples
//   are accepted on a valid/ready handshake; each tick releases exactly one
//   registered sample with a one-cycle m_strobe. An enabled tick on an empty
//   FIFO emits IDLE_VALUE and sets the sticky underrun flag; a disabled tick
//   emits IDLE_VALUE without popping.
//   clk, rst      : clock, asynchronous active-low reset
//   enable        : ticks pop the FIFO when high
//   tick          : one-cycle sample strobe
//   clr_underrun  : synchronous clear of underrun (a same-cycle set wins)
//   underrun      : sticky underrun flag
//   level         : FIFO occupancy, 0..DEPTH
//   bus (slave)   : s_data/s_valid/s_ready in, m_data/m_strobe out
module tick_sample_fifo
  import tick_sample_fifo_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = SAMPLE_WIDTH,
  parameter int unsigned           DEPTH      = 16,
  parameter logic [DATA_WIDTH-1:0] IDLE_VALUE = DATA_WIDTH'(IDLE_MIDSCALE)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          tick,
  input  logic                          clr_underrun,
  output logic                          underrun,
  output logic [level_width(DEPTH)-1:0] level,
  tick_sample_fifo_if.slave             bus
);

  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;
  logic                  starve;

  logic [DATA_WIDTH-1:0] m_data_q,   m_data_d;
  logic                  m_strobe_q, m_strobe_d;
  logic                  underrun_q, underrun_d;

  sync_fifo_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (bus.s_valid),
    .wr_data_i (bus.s_data),
    .rd_en_i   (pop),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (level)
  );

  // Readiness depends only on occupancy, never on tick or s_valid.
  assign bus.s_ready = !fifo_full;

  assign pop    = tick && enable && !fifo_empty;
  assign starve = tick && enable &&  fifo_empty;

  always_comb begin
    m_data_d   = m_data_q;
    m_strobe_d = tick;
    underrun_d = underrun_q;
    if (tick) begin
      m_data_d = pop ? fifo_rd_data : IDLE_VALUE;
    end
    // Set has priority over clear so an underrun in the clear cycle is kept.
    if (starve) begin
      underrun_d = 1'b1;
    end else if (clr_underrun) begin
      underrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_data_q   <= IDLE_VALUE;
      m_strobe_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      m_data_q   <= m_data_d;
      m_strobe_q <= m_strobe_d;
      underrun_q <= underrun_d;
    end
  end

  assign bus.m_data   = m_data_q;
  assign bus.m_strobe = m_strobe_q;
  assign underrun     = underrun_q;

endmodule : tick_sample_fifo

// File: doc/tick_sample_fifo.md
Name: tick_sample_fifo

Overview:
- Sample buffer placed directly downstream of the terminal-count tick generator in the TX chain.
- Accepts samples from the modulator or host side through a valid/ready handshake and stores them in a small FIFO.
- Releases exactly one sample per tick to the DAC/PWM output stage.
- On underrun, substitutes a fixed idle sample and raises a sticky flag.

Parameters:
- DATA_WIDTH, 8, sample width in bits.
- DEPTH, 16, FIFO entries; must be a power of two and at least 2.
- IDLE_VALUE, 8'h80, sample emitted when the FIFO is empty at a tick or when disabled (mid-scale for unsigned DAC).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- enable  input  1  when high, ticks pop the FIFO; when low, ticks emit IDLE_VALUE and never pop
- tick  input  1  one-cycle sample strobe from the upstream tick counter's tc
- s_data  input  DATA_WIDTH  incoming sample
- s_valid  input  1  s_data valid
- s_ready  output  1  FIFO can accept; high whenever level < DEPTH
- m_data  output  DATA_WIDTH  registered output sample to DAC
- m_strobe  output  1  one-cycle pulse marking a new m_data
- underrun  output  1  sticky: a tick found the FIFO empty while enable was high
- clr_underrun  input  1  synchronous clear of underrun
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

Behaviour:
- Reset (rst low, asynchronous):
  - Pointers, level and underrun go to 0; m_strobe goes to 0; m_data goes to IDLE_VALUE.
  - s_ready is 1 once reset is released.
- Push: on a clk edge with s_valid && s_ready, s_data is written at the write pointer and the write pointer increments.
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
- s_ready is combinational from level (level != DEPTH) only; it never depends on tick or s_valid.
- Pop: on a clk edge with tick && enable && level != 0:
  - m_data takes the entry at the read pointer; the read pointer increments; m_strobe is 1 for the next cycle.
- Latency: a tick sampled at edge N produces m_data and m_strobe valid after edge N, i.e. one cycle.
- Every tick produces an m_strobe pulse, whether it pops, underruns, or is disabled.
- Underrun: tick && enable && level == 0:
  - m_data takes IDLE_VALUE; m_strobe pulses; underrun is set.
  - A push in the same cycle is still accepted, so level ends at 1.
- Disabled: tick && !enable means m_data takes IDLE_VALUE, m_strobe pulses, no pop, underrun unchanged.
- Without a tick, m_strobe is 0 and m_data holds its value.
- Level update:
  - +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - Simultaneous push and pop is legal at any level except full, where s_ready is 0 and only the pop occurs.
- underrun: a set in the same cycle as clr_underrun wins, so the flag stays 1.
- Consecutive ticks on back-to-back cycles are supported: one pop per cycle.
- Reset asserted mid-operation discards FIFO contents immediately; no partial output is emitted.
- Storage is a register array with no read-during-write hazard: a pop reads the old entry even when the write targets the same index after wrap, because write only occurs when not full.

Decomposition:
- Shared TX package holds:
  - the sample-width constant, matching DATA_WIDTH;
  - the IDLE_VALUE mid-scale constant;
  - a level-width function ($clog2(DEPTH)+1).
- One natural sub-module: sync_fifo_core, which contains storage, pointers, level, and the full and empty flags.
- The top level adds tick/enable pop control, idle substitution, the m_strobe register and the underrun flag.

Test Plan:
- Reset with rst low for 3 cycles, then release: m_data=8'h80, m_strobe=0, level=0, s_ready=1, underrun=0.
- Push 0x10, 0x11, 0x12, then give 3 ticks 10 cycles apart with enable=1: m_data=0x10, 0x11, 0x12 each one cycle after its tick, m_strobe a single pulse each, level ending at 0.
- Push 16 samples with s_valid held high for 18 cycles: s_ready falls after the 16th, level=16, the 17th and 18th are not stored; one tick then returns the first sample and s_ready=1, level=15.
- Tick with an empty FIFO and enable=1: m_data=0x80, m_strobe pulse, underrun=1 stays set; assert clr_underrun for one cycle and underrun=0.
- Tick with the FIFO empty and s_valid=1, s_data=0x55 in the same cycle: underrun set, level=1; the next tick outputs 0x55.
- enable=0 with level=4 and 2 ticks: two 0x80 strobes, level stays 4; pulse rst low mid-stream: level=0 and m_data=0x80 immediately, asynchronously.
